// File: rtl/f_fetch_ctrl.sv
// Fetch-stage sequencer: owns the F-stage PC and the IF/ID register, runs the
// instruction-memory handshake and applies D-stage redirects after the delay slot.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | imem_req high at f_pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// HOLD  | word captured in the F buffer, waiting for stall to drop
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] fbuf_q, fbuf_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;

  logic        redirect_acc;
  logic        deliver;
  logic [31:0] deliver_word;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_acc = redirect_valid & d_valid_q & ~stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    fbuf_d       = fbuf_q;
    d_valid_d    = d_valid_q;
    d_pc_d       = d_pc_q;
    d_instr_d    = d_instr_q;
    deliver      = 1'b0;
    deliver_word = 32'h0;

    case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            state_d      = S_REQ;
          end else begin
            fbuf_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          deliver      = 1'b1;
          deliver_word = fbuf_q;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // A redirect seen on a delivery edge belongs to the word being delivered
    // (the delay slot), so the target goes straight into f_pc.
    if (deliver) begin
      if (redirect_acc)      pc_d = redirect_tgt;
      else if (pend_valid_q) pc_d = pend_pc_q;
      else                   pc_d = pc_q + 32'd4;
      pend_valid_d = 1'b0;
    end else if (redirect_acc) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_tgt;
    end

    if (!stall) begin
      if (deliver) begin
        d_valid_d = 1'b1;
        d_pc_d    = pc_q;
        d_instr_d = deliver_word;
      end else begin
        d_valid_d = 1'b0;
        d_instr_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= RESET_PC;
      fbuf_q       <= 32'h0;
      d_valid_q    <= 1'b0;
      d_pc_q       <= RESET_PC;
      d_instr_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      fbuf_q       <= fbuf_d;
      d_valid_q    <= d_valid_d;
      d_pc_q       <= d_pc_d;
      d_instr_q    <= d_instr_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign f_pc      = pc_q;
  assign d_valid   = d_valid_q;
  assign d_pc      = d_pc_q;
  assign d_instr   = d_instr_q;

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Directed bench for f_fetch_ctrl: memory handshake, stalls, redirects with
// delay slot, reset mid-flight and PC wraparound, all with hand-derived values.
module tb_f_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc;
  logic        d_valid;
  logic [31:0] d_pc, d_instr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f_fetch_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .f_pc          (f_pc),
    .d_valid       (d_valid),
    .d_pc          (d_pc),
    .d_instr       (d_instr)
  );

  task automatic drv(input logic rst, input logic g, input logic rv,
                     input logic [31:0] rd, input logic st,
                     input logic rdv, input logic [31:0] rpc);
    reset_n        = rst;
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    stall          = st;
    redirect_valid = rdv;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic req, input logic [31:0] pc);
    chk({tag, ".req"},  {31'h0, imem_req}, {31'h0, req});
    chk({tag, ".addr"}, imem_addr, pc);
    chk({tag, ".f_pc"}, f_pc, pc);
  endtask

  task automatic chk_d(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins);
    chk({tag, ".d_valid"}, {31'h0, d_valid}, {31'h0, v});
    chk({tag, ".d_pc"},    d_pc, pc);
    chk({tag, ".d_instr"}, d_instr, ins);
  endtask

  initial begin
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);
    step(); step();
    chk_f("rst", 1, 32'h3000);
    chk_d("rst", 0, 32'h3000, 32'h0);

    // zero-wait memory, rdata = address
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);     step(); chk_f("zw1", 0, 32'h3000); chk_d("zw1", 0, 32'h3000, 32'h0);
    drv(1, 0, 1, 32'h3000, 0, 0, 32'h0);  step(); chk_f("zw2", 1, 32'h3004); chk_d("zw2", 1, 32'h3000, 32'h3000);
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);     step(); chk_f("zw3", 0, 32'h3004); chk_d("zw3", 0, 32'h3000, 32'h0);
    drv(1, 0, 1, 32'h3004, 0, 0, 32'h0);  step(); chk_f("zw4", 1, 32'h3008); chk_d("zw4", 1, 32'h3004, 32'h3004);

    // gnt three cycles late, rvalid two cycles late
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);     step(); chk_f("sl_rst", 1, 32'h3000); chk_d("sl_rst", 0, 32'h3000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 32'h0, 0, 0, 32'h0);   step(); chk_f("sl_gw", 1, 32'h3000);
    end
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);     step(); chk_f("sl_g", 0, 32'h3000);
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 0, 32'h0, 0, 0, 32'h0);   step(); chk_f("sl_rw", 0, 32'h3000); chk_d("sl_rw", 0, 32'h3000, 32'h0);
    end
    drv(1, 0, 1, 32'h3000, 0, 0, 32'h0);  step(); chk_f("sl_r", 1, 32'h3004); chk_d("sl_r", 1, 32'h3000, 32'h3000);

    // stall across rvalid: FSM parks in HOLD, stray rvalid ignored, buffered word delivered
    drv(1, 1, 0, 32'h0, 1, 0, 32'h0);         step(); chk_f("st1", 0, 32'h3004); chk_d("st1", 1, 32'h3000, 32'h3000);
    drv(1, 0, 0, 32'h0, 1, 0, 32'h0);         step(); chk_f("st2", 0, 32'h3004); chk_d("st2", 1, 32'h3000, 32'h3000);
    drv(1, 0, 1, 32'hDEAD_3004, 1, 0, 32'h0); step(); chk_f("st3", 0, 32'h3004); chk_d("st3", 1, 32'h3000, 32'h3000);
    drv(1, 0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0); step(); chk_f("st4", 0, 32'h3004); chk_d("st4", 1, 32'h3000, 32'h3000);
    drv(1, 0, 0, 32'h0, 0, 0, 32'h0);         step(); chk_f("st5", 1, 32'h3008); chk_d("st5", 1, 32'h3004, 32'hDEAD_3004);

    // redirect while F waits on the delay slot; goes pending
    drv(0, 0, 0, 32'h0, 0, 0, 32'h0);         step();
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);         step();
    drv(1, 0, 1, 32'h3000, 0, 0, 32'h0);      step(); chk_d("rd0", 1, 32'h3000, 32'h3000);
    drv(1, 1, 0, 32'h0, 0, 1, 32'h3400);      step(); chk_f("rd1", 0, 32'h3004); chk_d("rd1", 0, 32'h3000, 32'h0);
    drv(1, 0, 0, 32'h0, 0, 1, 32'h5000);      step(); chk_f("rd2", 0, 32'h3004); chk_d("rd2", 0, 32'h3000, 32'h0);
    drv(1, 0, 1, 32'h3004, 0, 0, 32'h0);      step(); chk_f("rd3", 1, 32'h3400); chk_d("rd3", 1, 32'h3004, 32'h3004);
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);         step(); chk_f("rd4", 0, 32'h3400);
    drv(1, 0, 1, 32'h3400, 0, 0, 32'h0);      step(); chk_f("rd5", 1, 32'h3404); chk_d("rd5", 1, 32'h3400, 32'h3400);

    // redirect coincident with delivery of the delay slot, unaligned target
    drv(1, 1, 0, 32'h0, 1, 0, 32'h0);         step(); chk_f("co1", 0, 32'h3404); chk_d("co1", 1, 32'h3400, 32'h3400);
    drv(1, 0, 1, 32'h3404, 0, 1, 32'h3403);   step(); chk_f("co2", 1, 32'h3400); chk_d("co2", 1, 32'h3404, 32'h3404);
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);         step(); chk_f("co3", 0, 32'h3400); chk_d("co3", 0, 32'h3404, 32'h0);
    drv(1, 0, 1, 32'h3400, 0, 0, 32'h0);      step(); chk_f("co4", 1, 32'h3404); chk_d("co4", 1, 32'h3400, 32'h3400);

    // reset in WAIT with a pending redirect and a stale rvalid
    drv(1, 1, 0, 32'h0, 0, 1, 32'h3800);      step(); chk_f("mr1", 0, 32'h3404); chk_d("mr1", 0, 32'h3400, 32'h0);
    drv(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0); step(); chk_f("mr2", 1, 32'h3000); chk_d("mr2", 0, 32'h3000, 32'h0);
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);         step(); chk_f("mr3", 0, 32'h3000);
    drv(1, 0, 1, 32'h3000, 0, 0, 32'h0);      step(); chk_f("mr4", 1, 32'h3004); chk_d("mr4", 1, 32'h3000, 32'h3000);

    // PC wraparound from the top of the address space
    drv(1, 1, 0, 32'h0, 1, 0, 32'h0);         step(); chk_f("wr1", 0, 32'h3004);
    drv(1, 0, 1, 32'h3004, 0, 1, 32'hFFFF_FFFC); step(); chk_f("wr2", 1, 32'hFFFF_FFFC); chk_d("wr2", 1, 32'h3004, 32'h3004);
    drv(1, 1, 0, 32'h0, 0, 0, 32'h0);         step(); chk_f("wr3", 0, 32'hFFFF_FFFC);
    drv(1, 0, 1, 32'h1234_5678, 0, 0, 32'h0); step(); chk_f("wr4", 1, 32'h0); chk_d("wr4", 1, 32'hFFFF_FFFC, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
